input_debounce: RTL and testbench



---
 rtl/input_debounce_if.sv | 14 +
 rtl/input_debounce.sv | 83 ++++++++
 tb/tb_input_debounce.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/input_debounce_if.sv
// Signal bundle between the raw switch/button inputs and the debouncer.
// The master drives the raw levels and the slave returns the clean levels and edge pulses.
interface input_debounce_if #(
  parameter int N = 10
);
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         changed;

  modport master (output din, input dout, rise, fall, changed);
  modport slave  (input din, output dout, rise, fall, changed);
endinterface

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for raw switches/buttons.
// dout follows an input only after it has differed from dout for STABLE_CYCLES clocks.
module input_debounce #(
  parameter int N             = 10,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic              clk,
  input  logic              clr,
  input_debounce_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (STABLE_CYCLES < 1 || (STABLE_CYCLES >> CNT_W) != 0) begin : g_bad_params
    $error("input_debounce: need STABLE_CYCLES >= 1 and 2**CNT_W > STABLE_CYCLES");
  end

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [CNT_W-1:0] r_cnt [N];
  logic [N-1:0]     r_dout;
  logic [N-1:0]     r_rise;
  logic [N-1:0]     r_fall;
  logic             r_changed;

  logic [CNT_W-1:0] w_cnt_nxt [N];
  logic [N-1:0]     w_dout_nxt;
  logic [N-1:0]     w_rise_nxt;
  logic [N-1:0]     w_fall_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dout_nxt = r_dout;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (r_s2[i] == r_dout[i]) begin
        // Any sample that agrees with dout restarts the whole stability window.
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_dout_nxt[i] = r_s2[i];
        w_cnt_nxt[i]  = '0;
        w_rise_nxt[i] = r_s2[i];
        w_fall_nxt[i] = ~r_s2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_dout    <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      // NOTE: the counter array is reset explicitly; a mid-count clear must discard partial windows.
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= bus.din;
      r_s2      <= r_s1;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign bus.dout    = r_dout;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.changed = r_changed;

endmodule

// File: tb/tb_input_debounce.sv
// Vector-table bench for input_debounce with STABLE_CYCLES=4: each row is one clock of stimulus
// and the expected outputs after that edge; a scoreboard queue carries expectations to the checker.
module tb_input_debounce;

  localparam int N  = 10;
  localparam int SC = 4;

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         chg;
  } vec_t;

  logic clk;
  logic clr;

  input_debounce_if #(.N(N)) bus_if ();

  input_debounce #(
    .N             (N),
    .STABLE_CYCLES (SC),
    .CNT_W         (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vq_main [$];
  vec_t vq_post [$];
  vec_t sb_q    [$];
  bit   to_post;
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int reps, input logic [N-1:0] din, input logic [N-1:0] dout,
                     input logic [N-1:0] rise, input logic [N-1:0] fall, input logic chg);
    vec_t v;
    v.din = din; v.dout = dout; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int r = 0; r < reps; r++) begin
      if (to_post) vq_post.push_back(v);
      else         vq_main.push_back(v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".dout"},    bus_if.dout,          '0);
    check({tag, ".rise"},    bus_if.rise,          '0);
    check({tag, ".fall"},    bus_if.fall,          '0);
    check({tag, ".changed"}, N'(bus_if.changed),   '0);
  endtask

  // Entered and left at a falling edge: drive, push expectation, clock, pop and compare.
  task automatic run(input bit post);
    int   cnt;
    vec_t v;
    vec_t e;
    cnt = post ? vq_post.size() : vq_main.size();
    for (int i = 0; i < cnt; i++) begin
      v = post ? vq_post[i] : vq_main[i];
      bus_if.din = v.din;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("%s[%0d].dout", post ? "post" : "main", i), bus_if.dout, e.dout);
      check($sformatf("%s[%0d].rise", post ? "post" : "main", i), bus_if.rise, e.rise);
      check($sformatf("%s[%0d].fall", post ? "post" : "main", i), bus_if.fall, e.fall);
      check($sformatf("%s[%0d].chg",  post ? "post" : "main", i), N'(bus_if.changed), N'(e.chg));
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // 1: idle after reset
    to_post = 1'b0;
    add(20, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
    // 2: din[0] rises; dout follows at the 5th edge after the first sampling edge
    add(5,  10'h001, 10'h000, 10'h000, 10'h000, 1'b0);
    add(1,  10'h001, 10'h001, 10'h001, 10'h000, 1'b1);
    add(3,  10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
    // 3: din[3] high for 3 cycles only (one short of qualifying)
    add(3,  10'h009, 10'h001, 10'h000, 10'h000, 1'b0);
    add(8,  10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
    // 4: din[5] bounces 1,0,1,1,0,1 then holds 1
    add(1,  10'h021, 10'h001, 10'h000, 10'h000, 1'b0);
    add(1,  10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
    add(2,  10'h021, 10'h001, 10'h000, 10'h000, 1'b0);
    add(1,  10'h001, 10'h001, 10'h000, 10'h000, 1'b0);
    add(5,  10'h021, 10'h001, 10'h000, 10'h000, 1'b0);
    add(1,  10'h021, 10'h021, 10'h020, 10'h000, 1'b1);
    add(2,  10'h021, 10'h021, 10'h000, 10'h000, 1'b0);
    // bits 0 and 5 fall together
    add(5,  10'h000, 10'h021, 10'h000, 10'h000, 1'b0);
    add(1,  10'h000, 10'h000, 10'h000, 10'h021, 1'b1);
    add(2,  10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
    // 5: din[1] and din[9] rise together, then din[1] falls
    add(5,  10'h202, 10'h000, 10'h000, 10'h000, 1'b0);
    add(1,  10'h202, 10'h202, 10'h202, 10'h000, 1'b1);
    add(2,  10'h202, 10'h202, 10'h000, 10'h000, 1'b0);
    add(5,  10'h200, 10'h202, 10'h000, 10'h000, 1'b0);
    add(1,  10'h200, 10'h200, 10'h000, 10'h002, 1'b1);
    add(2,  10'h200, 10'h200, 10'h000, 10'h000, 1'b0);
    // 6 (prefix): bring dout[2] up, then start a fall count
    add(5,  10'h204, 10'h200, 10'h000, 10'h000, 1'b0);
    add(1,  10'h204, 10'h204, 10'h004, 10'h000, 1'b1);
    add(1,  10'h204, 10'h204, 10'h000, 10'h000, 1'b0);
    add(3,  10'h200, 10'h204, 10'h000, 10'h000, 1'b0);
    // after clear: din[9] held through reset rises after full latency, bit 2 stays quiet
    to_post = 1'b1;
    add(5,  10'h200, 10'h000, 10'h000, 10'h000, 1'b0);
    add(1,  10'h200, 10'h200, 10'h200, 10'h000, 1'b1);
    add(3,  10'h200, 10'h200, 10'h000, 10'h000, 1'b0);

    bus_if.din = '0;
    clr        = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    clr = 1'b0;

    run(1'b0);

    // Asynchronous clear between edges, mid-count on bit 2
    #2;
    clr = 1'b1;
    #1;
    check_idle("clr_async");
    @(posedge clk);
    #1;
    check_idle("clr_held");
    @(negedge clk);
    clr = 1'b0;

    run(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
